fir_mac_engine: RTL and testbench



---
 rtl/fir_mac_engine.sv | 164 ++++++++++++++++
 tb/tb_fir_mac_engine.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_engine.sv
// ---------------------------------------------------------------------------
// fir_mac_engine
//
// Time-multiplexed N_TAPS-tap FIR filter. Owns the sample delay line, walks
// the coefficient RAM read address and performs one multiply-accumulate per
// clock. Each accepted sample produces one rounded, saturated 16-bit output.
//
// Ports
//   clk_m       processing clock (shared with the coefficient RAM read port)
//   rst_n       asynchronous active-low reset
//   din         signed input sample
//   din_valid   din is presented
//   din_ready   engine idle, a sample may be accepted
//   coef_addr   registered coefficient RAM read address
//   coef        signed coefficient RAM read data (2-cycle read latency)
//   dout        signed filter output, held until the next result
//   dout_valid  one-cycle pulse marking a new dout
// ---------------------------------------------------------------------------
module fir_mac_engine #(
    parameter int N_TAPS = 72,
    parameter int SHIFT  = 15
) (
    input  logic        clk_m,
    input  logic        rst_n,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [6:0]  coef_addr,
    input  logic [15:0] coef,
    output logic [15:0] dout,
    output logic        dout_valid
);

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(N_TAPS);

    localparam logic [6:0] LAST = 7'(N_TAPS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    // One extra bit of headroom so the rounding constant can never wrap.
    localparam logic signed [ACC_W:0] RND     = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(32767);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W + 1)'(-32768);

    // Round half up, arithmetic shift, then clamp to the 16-bit signed range.
    function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] t;
        t = ($signed({a[ACC_W-1], a}) + RND) >>> SHIFT;
        if (t > SAT_MAX) begin
            return DATA_W'(SAT_MAX);
        end else if (t < SAT_MIN) begin
            return DATA_W'(SAT_MIN);
        end
        return DATA_W'(t);
    endfunction

    logic [1:0]               state;
    logic [6:0]               wp;
    logic                     accept;

    logic signed [DATA_W-1:0] dline [N_TAPS];

    logic [6:0]               idx_p0;
    logic signed [DATA_W-1:0] sample_p1;
    logic                     vld_p1;
    logic signed [DATA_W-1:0] sample_p2;
    logic                     vld_p2;
    logic signed [COEF_W-1:0] coef_p2;
    logic signed [PROD_W-1:0] prod_p2;
    logic signed [ACC_W-1:0]  acc;

    assign accept  = (state == ST_IDLE) && din_valid && din_ready;
    assign coef_p2 = coef;
    assign prod_p2 = coef_p2 * sample_p2;

    // Control: sequencer, address generation and output register.
    always_ff @(posedge clk_m or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wp         <= '0;
            coef_addr  <= '0;
            din_ready  <= 1'b1;
            dout       <= '0;
            dout_valid <= 1'b0;
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            vld_p1     <= (state == ST_RUN);
            vld_p2     <= vld_p1;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_RUN;
                        coef_addr <= '0;
                        din_ready <= 1'b0;
                        wp        <= (wp == LAST) ? 7'd0 : 7'(wp + 7'd1);
                    end
                end
                ST_RUN: begin
                    if (coef_addr == LAST) begin
                        state <= ST_DRAIN;
                    end else begin
                        coef_addr <= 7'(coef_addr + 7'd1);
                    end
                end
                ST_DRAIN: begin
                    // Last tap is in the final MAC stage and nothing follows it.
                    if (vld_p2 && !vld_p1) begin
                        state <= ST_OUT;
                    end
                end
                default: begin
                    dout       <= round_sat(acc);
                    dout_valid <= 1'b1;
                    din_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    // Delay line: circular buffer, newest sample at the pre-advance wp.
    always_ff @(posedge clk_m or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAPS; i++) begin
                dline[i] <= '0;
            end
        end else if (accept) begin
            dline[wp] <= din;
        end
    end

    // Stage p0: delay-line index for tap k, walking backwards from newest.
    always_ff @(posedge clk_m) begin
        if (accept) begin
            idx_p0 <= wp;
        end else if (state == ST_RUN) begin
            idx_p0 <= (idx_p0 == 7'd0) ? LAST : 7'(idx_p0 - 7'd1);
        end
    end

    // Stage p1/p2: sample follows the RAM's two-cycle read latency.
    always_ff @(posedge clk_m) begin
        sample_p1 <= dline[idx_p0];
        sample_p2 <= sample_p1;
    end

    // Stage p3: accumulate the product of matched coefficient and sample.
    always_ff @(posedge clk_m) begin
        if (accept) begin
            acc <= '0;
        end else if (vld_p2) begin
            acc <= acc + ACC_W'(prod_p2);
        end
    end

endmodule

// File: tb/tb_fir_mac_engine.sv
// ---------------------------------------------------------------------------
// tb_fir_mac_engine
//
// Bench for fir_mac_engine: coefficient RAM model with 2-cycle read latency,
// a behavioural filter model (sample history as a newest-first queue, direct
// convolution sum), a per-cycle compare process, and directed plus random
// stimulus with literal expectations for impulse, rounding, saturation,
// handshake timing, delay-line wrap and mid-run reset.
// ---------------------------------------------------------------------------
module tb_fir_mac_engine;

    localparam int N  = 72;
    localparam int SH = 15;

    logic        clk_m = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [6:0]  coef_addr;
    logic [15:0] coef = '0;
    logic [15:0] dout;
    logic        dout_valid;

    fir_mac_engine #(.N_TAPS(N), .SHIFT(SH)) dut (
        .clk_m      (clk_m),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .coef_addr  (coef_addr),
        .coef       (coef),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk_m = ~clk_m;

    // Coefficient RAM: address register then data register.
    logic signed [15:0] h_mem [0:127];
    logic [6:0]         ram_addr_q = '0;

    initial forever begin
        @(posedge clk_m);
        ram_addr_q <= coef_addr;
        coef       <= h_mem[ram_addr_q];
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model
    longint hist[$];
    int     cyc       = 0;
    bit     busy      = 0;
    int     t_run     = 0;
    bit     acc_pulse = 0;
    longint cur_y     = 0;
    bit     exp_ready = 1;
    bit     exp_valid = 0;
    longint exp_dout  = 0;
    int     exp_addr  = 0;
    int     acc_cyc[$];

    function automatic longint model_out();
        longint y = 0;
        longint one = 1;
        longint r;
        for (int k = 0; k < hist.size(); k++) begin
            y += longint'(h_mem[k]) * hist[k];
        end
        r = (y + (one <<< (SH - 1))) >>> SH;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    initial forever begin
        @(posedge clk_m or negedge rst_n);
        if (!rst_n) begin
            hist.delete();
            busy = 0; t_run = 0; acc_pulse = 0;
            exp_ready = 1; exp_valid = 0; exp_dout = 0; exp_addr = 0;
        end else begin
            cyc++;
            acc_pulse = 0;
            exp_valid = 0;
            if (busy) begin
                t_run++;
                if (t_run <= N - 1) exp_addr = t_run;
                if (t_run == N + 3) begin
                    busy = 0; exp_valid = 1; exp_dout = cur_y; exp_ready = 1;
                end
            end else if (din_valid) begin
                hist.push_front(longint'($signed(din)));
                if (hist.size() > N) void'(hist.pop_back());
                cur_y = model_out();
                busy = 1; t_run = 0; exp_addr = 0; exp_ready = 0; acc_pulse = 1;
                acc_cyc.push_back(cyc);
            end
        end
    end

    // Per-cycle compare
    longint outs[$];
    int     dv_cyc[$];

    initial forever begin
        @(negedge clk_m);
        chk("dout_valid", longint'(dout_valid), longint'(exp_valid));
        chk("din_ready", longint'(din_ready), longint'(exp_ready));
        chk("coef_addr", longint'(coef_addr), longint'(exp_addr));
        chk("dout", longint'($signed(dout)), exp_dout);
        if (dout_valid) begin
            outs.push_back(longint'($signed(dout)));
            dv_cyc.push_back(cyc);
        end
    end

    function automatic longint out_at(input int i);
        return (i < outs.size()) ? outs[i] : -999999;
    endfunction

    task automatic send(input logic [15:0] v);
        int guard = 0;
        din = v;
        din_valid = 1'b1;
        forever begin
            @(posedge clk_m); #1;
            guard++;
            if (acc_pulse) break;
            if (guard > 200) begin
                chk("accept_timeout", guard, 0);
                break;
            end
        end
        din_valid = 1'b0;
    endtask

    task automatic wait_done();
        repeat (N + 6) @(posedge clk_m);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_m);
        rst_n = 1'b0;
        repeat (3) @(negedge clk_m);
        rst_n = 1'b1;
    endtask

    task automatic load_impulse_coefs();
        for (int k = 0; k < 128; k++) h_mem[k] = 16'(100 * (k + 1));
    endtask

    task automatic check_impulse(input string tag);
        chk({tag, "_count"}, outs.size(), N);
        for (int n = 0; n < N; n++) chk(tag, out_at(n), 50 * (n + 1));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: got no finish, expected finish before limit");
        $fatal(1, "timeout");
    end

    initial begin
        int start_cyc;
        for (int k = 0; k < 128; k++) h_mem[k] = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_din_ready", din_ready, 1);
        chk("reset_dout_valid", dout_valid, 0);
        chk("reset_coef_addr", coef_addr, 0);
        chk("reset_dout", dout, 0);
        repeat (3) @(negedge clk_m);
        rst_n = 1'b1;

        // Impulse response
        load_impulse_coefs();
        outs.delete();
        send(16'd16384);
        for (int i = 0; i < N - 1; i++) send(16'd0);
        wait_done();
        check_impulse("impulse");

        // Rounding
        for (int k = 0; k < 128; k++) h_mem[k] = '0;
        h_mem[0] = 16'sd1;
        outs.delete();
        send(16'd16384);
        send(16'hC000);
        send(16'hBFFF);
        wait_done();
        chk("round_pos_half", out_at(0), 1);
        chk("round_neg_half", out_at(1), 0);
        chk("round_neg_over", out_at(2), -1);

        // Saturation
        for (int k = 0; k < 128; k++) h_mem[k] = 16'sd32767;
        outs.delete();
        for (int i = 0; i < N; i++) send(16'h7FFF);
        wait_done();
        chk("sat_pos", out_at(N - 1), 32767);
        outs.delete();
        for (int i = 0; i < N; i++) send(16'h8000);
        wait_done();
        chk("sat_neg", out_at(N - 1), -32768);

        // Handshake: din_valid held high
        for (int k = 0; k < 128; k++) h_mem[k] = 16'($urandom);
        acc_cyc.delete();
        dv_cyc.delete();
        start_cyc = cyc;
        din_valid = 1'b1;
        for (int i = 0; i < 160; i++) begin
            din = 16'($urandom);
            @(posedge clk_m); #1;
        end
        din_valid = 1'b0;
        wait_done();
        chk("hs_accept_count", acc_cyc.size(), 3);
        chk("hs_first_accept", (acc_cyc.size() > 0) ? acc_cyc[0] - start_cyc : -1, 1);
        chk("hs_accept_spacing", (acc_cyc.size() > 1) ? acc_cyc[1] - acc_cyc[0] : -1, 76);
        chk("hs_latency", (dv_cyc.size() > 0 && acc_cyc.size() > 0) ? dv_cyc[0] - acc_cyc[0] : -1, 75);
        chk("hs_out_spacing", (dv_cyc.size() > 1) ? dv_cyc[1] - dv_cyc[0] : -1, 76);

        // Random coefficients, samples and gaps
        for (int k = 0; k < 128; k++) h_mem[k] = 16'($urandom);
        for (int j = 0; j < 30; j++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk_m);
            #1;
            send(16'($urandom));
        end
        wait_done();

        // Delay-line wrap
        do_reset();
        for (int k = 0; k < 128; k++) h_mem[k] = '0;
        h_mem[N - 1] = 16'sd32767;
        outs.delete();
        for (int i = 0; i < 150; i++) send(16'(i));
        wait_done();
        chk("wrap_count", outs.size(), 150);
        chk("wrap_0", out_at(0), 0);
        chk("wrap_70", out_at(70), 0);
        chk("wrap_71", out_at(71), 0);
        chk("wrap_72", out_at(72), 1);
        chk("wrap_100", out_at(100), 29);
        chk("wrap_149", out_at(149), 78);

        // Reset mid-run
        load_impulse_coefs();
        outs.delete();
        send(16'd16384);
        repeat (40) @(posedge clk_m);
        #1;
        chk("prereset_coef_addr", coef_addr, 40);
        rst_n = 1'b0;
        #1;
        chk("midreset_dout_valid", dout_valid, 0);
        chk("midreset_din_ready", din_ready, 1);
        chk("midreset_coef_addr", coef_addr, 0);
        repeat (3) @(negedge clk_m);
        rst_n = 1'b1;
        repeat (N + 6) @(posedge clk_m);
        #1;
        chk("midreset_no_pulse", outs.size(), 0);
        send(16'd16384);
        for (int i = 0; i < N - 1; i++) send(16'd0);
        wait_done();
        check_impulse("impulse_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
